// File: rtl/arith_op_issue.sv
// arith_op_issue: issue/return stage for a fixed-latency ALU.
// Command FIFO -> ALU operand regs -> in-flight pipe -> result FIFO.
module arith_op_issue #(
  parameter int CMD_DEPTH = 4,
  parameter int RES_DEPTH = 4,
  parameter int ALU_LAT   = 2,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [1:0]       in_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [1:0]       alu_sel,
  input  logic [31:0]      alu_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_r,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dz,
  output logic             busy
);
  localparam int CPW = $clog2(CMD_DEPTH);
  localparam int RPW = $clog2(RES_DEPTH);
  localparam int NW  = $clog2(RES_DEPTH + ALU_LAT + 2) + 2;

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [1:0]       sel;
    logic [TAG_W-1:0] tag;
    logic             dz;
  } cmd_t;

  typedef struct packed {
    logic [31:0]      r;
    logic [TAG_W-1:0] tag;
    logic             dz;
  } res_t;

  cmd_t             cmd_mem [CMD_DEPTH];
  logic [CPW-1:0]   cmd_wp, cmd_rp;
  logic [CPW:0]     cmd_cnt, cmd_cnt_nxt;
  logic             rdy_q;

  res_t             res_mem [RES_DEPTH];
  logic [RPW-1:0]   res_wp, res_rp;
  logic [RPW:0]     res_cnt;

  logic [ALU_LAT:0] pv, pdz;
  logic [TAG_W-1:0] ptag [ALU_LAT+1];

  logic             push, issue, cap, pop;
  logic [NW-1:0]    occ;
  cmd_t             head;
  res_t             rhead;

  assign in_ready  = rdy_q;
  assign push      = in_valid & rdy_q;
  assign head      = cmd_mem[cmd_rp];
  assign cap       = pv[ALU_LAT];
  assign out_valid = (res_cnt != '0);
  assign pop       = out_valid & out_ready;
  assign rhead     = res_mem[res_rp];
  assign out_r     = rhead.r;
  assign out_tag   = rhead.tag;
  assign out_dz    = rhead.dz;
  assign busy      = (cmd_cnt != '0) | (|pv) | (res_cnt != '0);

  // Reserved result slots: ops in flight plus results not yet popped.
  always_comb begin
    occ = NW'(res_cnt);
    for (int i = 0; i <= ALU_LAT; i++)
      occ = occ + NW'(pv[i]);
  end

  // A pop this edge frees its slot in time for an issue on the same edge.
  assign issue = (cmd_cnt != '0) &&
                 (occ < NW'(RES_DEPTH) + NW'(pop));

  assign cmd_cnt_nxt = cmd_cnt + (CPW+1)'(push)
                               - (CPW+1)'(issue);

  // Command FIFO: pointers, count and registered not-full flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_wp  <= '0;
      cmd_rp  <= '0;
      cmd_cnt <= '0;
      rdy_q   <= 1'b0;
      for (int i = 0; i < CMD_DEPTH; i++)
        cmd_mem[i] <= '0;
    end else begin
      if (push) begin
        cmd_mem[cmd_wp] <= {in_a, in_b, in_sel, in_tag,
                            (in_sel == 2'd3) && (in_b == 32'd0)};
        cmd_wp <= cmd_wp + 1'b1;
      end
      if (issue)
        cmd_rp <= cmd_rp + 1'b1;
      cmd_cnt <= cmd_cnt_nxt;
      rdy_q   <= (cmd_cnt_nxt != (CPW+1)'(CMD_DEPTH));
    end
  end

  // ALU operand registers: load on issue, otherwise hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
    end else if (issue) begin
      alu_a   <= head.a;
      alu_b   <= head.b;
      alu_sel <= head.sel;
    end
  end

  // In-flight pipe: tail is valid on the edge alu_r holds the result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv  <= '0;
      pdz <= '0;
      for (int i = 0; i <= ALU_LAT; i++)
        ptag[i] <= '0;
    end else begin
      pv      <= {pv[ALU_LAT-1:0], issue};
      pdz     <= {pdz[ALU_LAT-1:0], issue & head.dz};
      ptag[0] <= issue ? head.tag : '0;
      for (int i = 1; i <= ALU_LAT; i++)
        ptag[i] <= ptag[i-1];
    end
  end

  // Result FIFO: capture from the pipe tail, pop on handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_wp  <= '0;
      res_rp  <= '0;
      res_cnt <= '0;
      for (int i = 0; i < RES_DEPTH; i++)
        res_mem[i] <= '0;
    end else begin
      if (cap) begin
        res_mem[res_wp] <= {alu_r, ptag[ALU_LAT], pdz[ALU_LAT]};
        res_wp <= res_wp + 1'b1;
      end
      if (pop)
        res_rp <= res_rp + 1'b1;
      res_cnt <= res_cnt + (RPW+1)'(cap) - (RPW+1)'(pop);
    end
  end

endmodule

// File: tb/tb_arith_op_issue.sv
// tb_arith_op_issue: random and directed checks of arith_op_issue
// against an in-bench ALU model and an in-order result scoreboard.
module tb_arith_op_issue;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic [1:0]  in_sel;
  logic [3:0]  in_tag;
  logic [31:0] alu_a, alu_b;
  logic [1:0]  alu_sel;
  logic [31:0] alu_r;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_r;
  logic [3:0]  out_tag;
  logic        out_dz;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  int n_pop   = 0;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  tag;
    logic        dz;
  } exp_t;

  exp_t q[$];
  exp_t e;

  arith_op_issue #(
    .CMD_DEPTH(4), .RES_DEPTH(4), .ALU_LAT(2), .TAG_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_tag(in_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_r(alu_r),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_tag(out_tag), .out_dz(out_dz),
    .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // ALU model: two-stage pipe, computed with 64-bit arithmetic.
  function automatic logic [31:0] alu_f(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [1:0]  s);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (s)
      2'd0:    return 32'(sa + sb);
      2'd1:    return 32'(sa - sb);
      2'd2:    return 32'(sa * sb);
      default: return (sb == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
    endcase
  endfunction

  logic [31:0] s1, s2;
  always @(posedge clk) begin
    s1 <= alu_f(alu_a, alu_b, alu_sel);
    s2 <= s1;
  end
  assign alu_r = s2;

  // Reference result of a request, from the arithmetic definition.
  function automatic logic [31:0] ref_r(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [1:0]  s);
    logic signed [31:0] qv;
    case (s)
      2'd0: return a + b;
      2'd1: return a - b;
      2'd2: return a * b;
      default: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        qv = $signed(a) / $signed(b);
        return qv;
      end
    endcase
  endfunction

  // Scoreboard: record on acceptance, compare on pop.
  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_pop++;
        chk("pop_has_exp", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("res", {out_r, out_tag, out_dz}, {e.r, e.tag, e.dz});
        end
      end
      if (in_valid && in_ready) begin
        n_acc++;
        e.r   = ref_r(in_a, in_b, in_sel);
        e.tag = in_tag;
        e.dz  = (in_sel == 2'd3) && (in_b == 32'd0);
        q.push_back(e);
      end
    end
  end

  task automatic new_op();
    in_a   = $urandom;
    case ($urandom_range(0, 3))
      0:       in_b = 32'd0;
      1:       in_b = 32'($urandom_range(1, 9));
      2:       in_b = -32'($urandom_range(1, 9));
      default: in_b = $urandom;
    endcase
    in_sel = 2'($urandom);
    in_tag = 4'($urandom);
    if (in_sel == 2'd3 && in_a == 32'h8000_0000 &&
        in_b == 32'hFFFF_FFFF)
      in_b = 32'd1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] s, input logic [3:0] t);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_a = a; in_b = b; in_sel = s; in_tag = t;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    chk("send_acc", 64'(ok), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    logic idle;
    idle = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 3000 && !idle; i++) begin
      @(negedge clk);
      idle = !busy;
    end
    chk("drain_idle", 64'(idle), 64'd1);
    chk("drain_q", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    chk("wait_out", 64'(seen), 64'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, p0, acc_cnt, sent;
    logic ok, have, seen;
    logic [31:0] held;

    rst = 0; in_valid = 0; in_a = 0; in_b = 0;
    in_sel = 0; in_tag = 0; out_ready = 1;

    // Reset state.
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out", {out_r, out_tag, out_dz}, 64'd0);
    chk("rst_alu", {alu_a, alu_b, alu_sel}, 64'd0);
    #10 rst = 1;
    #1 chk("rel_in_ready0", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("rel_in_ready1", 64'(in_ready), 64'd1);

    // Test 1: single op latency.
    send(32'd7, 32'd5, 2'd0, 4'd3);
    chk("t1_busy", 64'(busy), 64'd1);
    repeat (3) @(posedge clk);
    #1 chk("t1_early", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1 chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_res", {out_r, out_tag, out_dz},
        {32'd12, 4'd3, 1'b0});
    drain();

    // Test 2: divide by zero, then signed truncating divide.
    out_ready = 1'b0;
    send(32'd100, 32'd0, 2'd3, 4'd5);
    send(-32'sd9, 32'd2, 2'd3, 4'd6);
    wait_out(seen);
    chk("t2_dz", {out_r, out_tag, out_dz},
        {32'hFFFF_FFFF, 4'd5, 1'b1});
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    wait_out(seen);
    chk("t2_div", {out_r, out_tag, out_dz},
        {32'hFFFF_FFFC, 4'd6, 1'b0});
    drain();

    // Test 3: 64 back-to-back ops at full rate.
    a0 = n_acc;
    out_ready = 1'b1;
    new_op();
    in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      chk("t3_rdy", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      if (i < 63) new_op();
    end
    in_valid = 1'b0;
    chk("t3_acc", 64'(n_acc - a0), 64'd64);
    drain();

    // Test 4: back-pressure fills both FIFOs.
    a0 = n_acc; p0 = n_pop;
    out_ready = 1'b0;
    acc_cnt = 0; have = 1'b0; held = '0;
    new_op();
    in_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      ok = in_valid & in_ready;
      if (have) chk("t4_stable", 64'(out_r), 64'(held));
      if (out_valid && !have) begin
        held = out_r;
        have = 1'b1;
      end
      @(posedge clk); #1;
      if (ok) begin
        acc_cnt++;
        new_op();
      end
      in_valid = (acc_cnt < 10);
    end
    in_valid = 1'b0;
    chk("t4_acc", 64'(acc_cnt), 64'd8);
    chk("t4_rdy", 64'(in_ready), 64'd0);
    chk("t4_out_valid", 64'(out_valid), 64'd1);
    drain();
    chk("t4_pops", 64'(n_pop - p0), 64'(n_acc - a0));
    chk("t4_pops8", 64'(n_pop - p0), 64'd8);

    // Test 5: random traffic and back-pressure, 1000 ops.
    a0 = n_acc;
    sent = 0;
    new_op();
    in_valid = 1'b1;
    for (int i = 0; i < 20000 && sent < 1000; i++) begin
      @(negedge clk);
      ok = in_valid & in_ready;
      @(posedge clk); #1;
      if (ok) sent++;
      if (!in_valid || ok) begin
        new_op();
        in_valid = (sent < 1000) && ($urandom_range(0, 1) == 1);
      end
      out_ready = 1'($urandom);
    end
    in_valid = 1'b0;
    chk("t5_sent", 64'(sent), 64'd1000);
    chk("t5_acc", 64'(n_acc - a0), 64'd1000);
    drain();

    // Test 6: reset with three ops in flight.
    out_ready = 1'b1;
    new_op();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_rdy", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      if (i < 2) new_op();
    end
    in_valid = 1'b0;
    @(posedge clk); #2;
    chk("t6_busy_pre", 64'(busy), 64'd1);
    p0 = n_pop;
    rst = 1'b0;
    #1;
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_out_valid", 64'(out_valid), 64'd0);
    chk("t6_in_ready", 64'(in_ready), 64'd0);
    chk("t6_alu", {alu_a, alu_b, alu_sel}, 64'd0);
    chk("t6_out", {out_r, out_tag, out_dz}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t6_quiet", {out_valid, busy}, 64'd0);
    end
    chk("t6_no_pop", 64'(n_pop - p0), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
